// File: rtl/spi_slave_rx.sv
// SPI responder: oversamples cs/sclk/mosi, deserialises MSB-first frames and shifts a response out on miso.
// Optional SPI_SLAVE_OVERRUN_EN adds rx_ack/overrun flow-control signalling.
module spi_slave_rx #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             sclk,
    input  logic             mosi,
    input  logic [WIDTH-1:0] tx_data,
`ifdef SPI_SLAVE_OVERRUN_EN
    input  logic             rx_ack,
    output logic             overrun,
`endif
    output logic             miso,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic [4:0]       bit_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [4:0] LAST_BIT = 5'(WIDTH - 1);

    logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   cs_prev_q, sclk_prev_q;
    logic                   armed_q;
    logic                   cs_cur, sclk_cur, mosi_cur;
    logic                   cs_fall, cs_rise, sclk_fall;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       tx_sr_q, tx_sr_d;
    logic [WIDTH-1:0]       rx_sr_q, rx_sr_d;
    logic [WIDTH-1:0]       rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]       rx_shift;

    assign cs_cur   = cs_sync_q[SYNC_STAGES-1];
    assign sclk_cur = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_cur = mosi_sync_q[SYNC_STAGES-1];

    // A cs falling edge only counts once cs has been seen high after reset, so a
    // frame already in flight when reset releases is skipped entirely.
    assign cs_fall   = armed_q & cs_prev_q & ~cs_cur;
    assign cs_rise   = ~cs_prev_q & cs_cur;
    assign sclk_fall = sclk_prev_q & ~sclk_cur;
    assign rx_shift  = {rx_sr_q[WIDTH-2:0], mosi_cur};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
            fill_q      <= '0;
            armed_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value,
            // which is what makes this a shift chain rather than a single wire.
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            cs_prev_q   <= cs_cur;
            sclk_prev_q <= sclk_cur;
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            armed_q     <= armed_q | (fill_q[SYNC_STAGES-1] & cs_cur);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            bit_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        bit_cnt_d  = bit_cnt_q;

        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (cs_fall) begin
                    tx_sr_d = tx_data;
                    rx_sr_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Completion wins over a coincident cs rise; abort wins over a partial sample.
                if (sclk_fall && bit_cnt_q == LAST_BIT) begin
                    rx_sr_d    = rx_shift;
                    tx_sr_d    = {tx_sr_q[WIDTH-2:0], 1'b0};
                    bit_cnt_d  = bit_cnt_q + 5'd1;
                    rx_data_d  = rx_shift;
                    rx_valid_d = 1'b1;
                    state_d    = DONE;
                end else if (cs_rise) begin
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end else if (sclk_fall) begin
                    rx_sr_d   = rx_shift;
                    tx_sr_d   = {tx_sr_q[WIDTH-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
            end
            DONE: begin
                bit_cnt_d = '0;
                if (!cs_cur) begin
                    tx_sr_d = tx_data;
                    rx_sr_d = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                bit_cnt_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    always_comb begin
        busy     = (state_q != IDLE);
        miso     = ~cs_prev_q & tx_sr_q[WIDTH-1];
        rx_data  = rx_data_q;
        rx_valid = rx_valid_q;
        bit_cnt  = bit_cnt_q;
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic pending_q, overrun_q;

    // An ack in the same cycle as rx_valid acknowledges the older word only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (rx_valid_q)
                pending_q <= 1'b1;
            else if (rx_ack)
                pending_q <= 1'b0;

            if (rx_ack)
                overrun_q <= 1'b0;
            else if (rx_valid_q && pending_q)
                overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`endif

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- SPI responder for the 16-bit master in the Protocolo_SPI block.
- Oversamples `cs`, `sclk` and `mosi` from the master on the local system clock.
- Deserialises each MSB-first frame into a parallel word and pulses `rx_valid` when the frame completes.
- Shifts a preloaded response word out on `miso` during the same frame, giving a full-duplex link back to the master's MISO input.

Parameters:
- WIDTH, 16: frame length in bits; width of `rx_data` and `tx_data`.
- SYNC_STAGES, 2: flip-flop stages on each of `cs`, `sclk` and `mosi` (minimum 2).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- cs  input  1  chip select from master, active-low.
- sclk  input  1  serial clock from master, idle low.
- mosi  input  1  serial data from master, MSB first.
- tx_data  input  WIDTH  response word, captured at frame start.
- miso  output  1  serial response, MSB first.
- rx_data  output  WIDTH  last completed received word.
- rx_valid  output  1  one-clk pulse: `rx_data` updated.
- busy  output  1  high while a frame is in progress.
- bit_cnt  output  5  bits received in the current frame (0..WIDTH).

Behaviour:
- Reset (`reset` low, asynchronous): all sync flops set to idle (`cs`=1, `sclk`=0, `mosi`=0).
  - `rx_data`=0, `rx_valid`=0, `busy`=0, `bit_cnt`=0, `miso`=0, tx shift register=0, state=IDLE.
- Reset deasserted mid-frame: the partial frame is lost; the block waits for the next `cs` falling edge.
- Synchronisation and edge detection:
  - `cs`, `sclk` and `mosi` each pass through SYNC_STAGES flops.
  - Edges are detected by comparing the last two synchronised `sclk`/`cs` samples.
  - Every output reacts SYNC_STAGES+1 clk cycles after the pin event.
- Timing requirement: the master holds `sclk` high and low for at least SYNC_STAGES+2 clk cycles each. Faster `sclk` is out of spec and its behaviour is undefined.
- Sampling: `mosi` is sampled on the synchronised `sclk` falling edge, because the master changes `mosi` together with the `sclk` rising edge.
  - Sampled bits shift into the rx shift register LSB-side, so the first bit ends up in `rx_data[WIDTH-1]`.
- MISO:
  - `miso` = tx shift register MSB while `cs` is low, and 0 while `cs` is high (no tristate).
  - The tx shift register shifts left (fill 0) on each sampling edge, after sampling.
- State machine:
  - IDLE: `busy`=0, `bit_cnt`=0. On `cs` falling edge: load tx shift register from `tx_data`, clear rx shift register, go to SHIFT.
  - SHIFT: `busy`=1. Each sampling edge increments `bit_cnt`. When `bit_cnt` reaches WIDTH: copy rx shift register to `rx_data`, pulse `rx_valid` on the next clk, go to DONE.
  - DONE (one cycle): if `cs` is still low, reload tx from `tx_data`, set `bit_cnt`=0 and go to SHIFT (back-to-back frames); otherwise go to IDLE.
- Abort: `cs` rising edge while in SHIFT with `bit_cnt` < WIDTH discards the partial word. No `rx_valid`, `rx_data` unchanged, go to IDLE.
- Simultaneous events:
  - `cs` rising on the same clk as the WIDTH-th sampling edge: the frame completes and `rx_valid` pulses.
  - `sclk` edges while `cs` is high are ignored.
- `rx_data` holds its value until the next completed frame.
- `rx_valid` is never high for more than one cycle.

Optional Feature:
- Macro: SPI_SLAVE_OVERRUN_EN.
- Defined: adds an input `rx_ack` (1 bit) and an output `overrun` (1 bit, reset 0).
  - An internal pending flag sets on `rx_valid` and clears on `rx_ack`.
  - A frame completing while pending is still set sets `overrun`, which stays set until `rx_ack`.
  - `rx_data` is still overwritten by the new word.
  - `rx_ack` coinciding with `rx_valid` counts as acknowledging the older word: pending stays set and `overrun` does not set.
- Not defined: neither port exists, and completed frames overwrite `rx_data` silently.

Test Plan:
- Reset low mid-frame after 7 bits -> all outputs 0 immediately. After release, a full frame 0xA5C3 gives `rx_data`=0xA5C3, one `rx_valid` pulse and `bit_cnt` back at 0.
- `tx_data`=0x8001, master sends 0x1234 with `sclk` half-period 4 clk -> `miso` bits observed at sampling edges = 1,0×14,1; `rx_data`=0x1234.
- `cs` raised after 9 bits of 0xFFFF -> no `rx_valid`, `rx_data` keeps its previous value 0x1234, `busy` falls within SYNC_STAGES+2 clk.
- `cs` held low for 32 bits, 0xBEEF then 0x0F0F -> two `rx_valid` pulses with `rx_data` 0xBEEF then 0x0F0F. `tx_data` changed from 0x1111 to 0x2222 between frames -> second frame shifts out 0x2222.
- `sclk` toggling with `cs` high for 20 edges -> `bit_cnt`=0, `busy`=0, `miso`=0, no `rx_valid`.
- With SPI_SLAVE_OVERRUN_EN: two frames, no `rx_ack` -> `overrun`=1 after the second `rx_valid`; `rx_ack` pulse -> `overrun`=0.
